adc_array_decoder_dwa: RTL and testbench

- Registered, parametrised binary-to-thermometer decoder for the SAR capacitor array: row, row-on, column and binary-cap enables, all active-low.
- Sits between the SAR logic and the array drivers, behind a valid/ready register stage.
- Adds data-weighted-averaging (DWA) column rotation and selectable column interleave, so unit-cap mismatch is spread across the array between conversions.

---
 rtl/adc_array_decoder_dwa.sv | 199 +++++++++++++++++++
 tb/tb_adc_array_decoder_dwa.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_array_decoder_dwa.sv
// -----------------------------------------------------------------------------
// adc_array_decoder_dwa
//
// Registered binary-to-thermometer decoder driving the SAR capacitor array.
// A data word {row, col, bin} is accepted through a valid/ready register stage.
// One cycle later it appears on the active-low row, row-on, column and
// binary-cap enables. Unit-cap mismatch is spread across the array in two ways.
// Columns can be taken in an alternate-ends physical order. With data-weighted
// averaging (DWA), the run of active columns starts where the previous run
// ended.
//
// Optional feature macro: ADC_DECODER_DWA_EN
//   defined   : DWA pointer register and column rotation are built.
//   undefined : rot_ptr is tied to 0, dwa_enable is ignored, and columns use
//               the plain thermometer code. No pointer register is built.
//
// Parameters
//   ROW_BITS       row field width, NR = 2**ROW_BITS rows
//   COL_BITS       column field width, NC = 2**COL_BITS columns
//   BIN_BITS       binary-cap field width
//   COL_INTERLEAVE 0 = linear column order, 1 = alternate-ends column order
//
// Ports
//   clk        clock (only clock)
//   rst        synchronous active-high reset
//   in_valid   data word offered
//   in_ready   decoder can accept a word (= !out_valid || out_ready)
//   data       {row, col, bin}, MSB to LSB
//   dwa_enable rotate columns for this word, sampled on accept
//   out_valid  outputs hold a decoded word
//   out_ready  consumer takes the word
//   row_n      active-low row enable            [NR]
//   rowon_n    active-low row fully-on          [NR]
//   col_n      active-low column enable         [NC]
//   bincap_n   active-low binary caps           [BIN_BITS]
//   c0_p       constant 1
//   c0_n       constant 0
//   rot_ptr    current DWA pointer              [COL_BITS]
// -----------------------------------------------------------------------------
module adc_array_decoder_dwa #(
    parameter int ROW_BITS       = 4,
    parameter int COL_BITS       = 5,
    parameter int BIN_BITS       = 3,
    parameter int COL_INTERLEAVE = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ROW_BITS+COL_BITS+BIN_BITS-1:0] data,
    input  logic                             dwa_enable,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [(2**ROW_BITS)-1:0]         row_n,
    output logic [(2**ROW_BITS)-1:0]         rowon_n,
    output logic [(2**COL_BITS)-1:0]         col_n,
    output logic [BIN_BITS-1:0]              bincap_n,
    output logic                             c0_p,
    output logic                             c0_n,
    output logic [COL_BITS-1:0]              rot_ptr
);

    localparam int NR     = 2**ROW_BITS;
    localparam int NC     = 2**COL_BITS;
    localparam int DATA_W = ROW_BITS + COL_BITS + BIN_BITS;

    // Logical column k to physical column. With interleave, consecutive
    // logical columns land at alternate ends of the array:
    // 0, NC-1, 1, NC-2, ...
    function automatic int phys_col(input int k);
        if (COL_INTERLEAVE == 0)
            return k;
        else if ((k % 2) == 0)
            return k / 2;
        else
            return NC - 1 - ((k - 1) / 2);
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0] r_f;
    logic [COL_BITS-1:0] c_f;
    logic [BIN_BITS-1:0] b_f;

    assign r_f = data[DATA_W-1 -: ROW_BITS];
    assign c_f = data[BIN_BITS +: COL_BITS];
    assign b_f = data[BIN_BITS-1:0];

    // ------------------------------------------------------------------
    // DWA pointer
    // ------------------------------------------------------------------
    logic [COL_BITS-1:0] rot_off;   // rotation applied to the word being accepted

`ifdef ADC_DECODER_DWA_EN
    logic [COL_BITS-1:0] rot_ptr_q;
    logic [COL_BITS-1:0] ptr_next;
    logic                unused_ptr_carry;

    // The sum is one bit wider than the pointer. Dropping the carry gives the
    // mod-NC wrap. c = NC-1 adds a full turn and leaves the pointer unchanged.
    assign {unused_ptr_carry, ptr_next} =
        {1'b0, rot_ptr_q} + {1'b0, c_f} + (COL_BITS+1)'(1);

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values, whatever order the simulator runs the
    // blocks in.
    always_ff @(posedge clk) begin
        if (rst)
            rot_ptr_q <= '0;
        else if (accept && dwa_enable)
            rot_ptr_q <= ptr_next;
    end

    assign rot_off = dwa_enable ? rot_ptr_q : '0;
    assign rot_ptr = rot_ptr_q;
`else
    logic unused_dwa_enable;

    assign unused_dwa_enable = dwa_enable;
    assign rot_off           = '0;
    assign rot_ptr           = '0;
`endif

    // ------------------------------------------------------------------
    // Decode of the incoming word (active-high)
    // ------------------------------------------------------------------
    logic [NR-1:0]       row_d;
    logic [NR-1:0]       rowon_d;
    logic [NC-1:0]       col_d;

    // NOTE: every vector is cleared before the loops. Each path through the
    // block then assigns every bit, so no latch can be inferred.
    always_comb begin
        row_d   = '0;
        rowon_d = '0;
        col_d   = '0;

        for (int j = 0; j < NR; j++) begin
            row_d[j]   = (int'(r_f) >= j);
            rowon_d[j] = (int'(r_f) >  j);
        end

        // Logical column k is active when its distance from the rotation
        // start, taken mod NC, is within the requested count. This gives
        // c+1 active columns.
        for (int k = 0; k < NC; k++) begin
            col_d[phys_col(k)] = (COL_BITS'(COL_BITS'(k) - rot_off) <= c_f);
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [NR-1:0]       row_q;
    logic [NR-1:0]       rowon_q;
    logic [NC-1:0]       col_q;
    logic [BIN_BITS-1:0] bin_q;
    logic                valid_q;

    // The data registers are reset as well as out_valid. Their reset value
    // is the released array (all enables off) and is visible on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            row_q   <= '0;
            rowon_q <= '0;
            col_q   <= '0;
            bin_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            row_q   <= row_d;
            rowon_q <= rowon_d;
            col_q   <= col_d;
            bin_q   <= b_f;
        end else if (valid_q && out_ready) begin
            // Drain: the decoded word stays on the pins, only valid drops.
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign row_n     = ~row_q;
    assign rowon_n   = ~rowon_q;
    assign col_n     = ~col_q;
    assign bincap_n  = ~bin_q;

    assign c0_p = 1'b1;
    assign c0_n = 1'b0;

endmodule

// File: tb/tb_adc_array_decoder_dwa.sv
// -----------------------------------------------------------------------------
// tb_adc_array_decoder_dwa
//
// Directed bench for adc_array_decoder_dwa with the default parameters
// (NR=16, NC=32, interleave on). Expected values were worked out by hand.
// The expected values for DWA-dependent outputs change with
// ADC_DECODER_DWA_EN.
// -----------------------------------------------------------------------------
module tb_adc_array_decoder_dwa;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] data;
    logic        dwa_enable;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] row_n;
    logic [15:0] rowon_n;
    logic [31:0] col_n;
    logic [2:0]  bincap_n;
    logic        c0_p;
    logic        c0_n;
    logic [4:0]  rot_ptr;

    int checks = 0;
    int errors = 0;

    adc_array_decoder_dwa #(
        .ROW_BITS      (4),
        .COL_BITS      (5),
        .BIN_BITS      (3),
        .COL_INTERLEAVE(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .dwa_enable(dwa_enable),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_n     (row_n),
        .rowon_n   (rowon_n),
        .col_n     (col_n),
        .bincap_n  (bincap_n),
        .c0_p      (c0_p),
        .c0_n      (c0_n),
        .rot_ptr   (rot_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word with out_ready high. The call returns at the negedge after
    // the accepting posedge, with in_valid already dropped.
    task automatic send(input logic [11:0] d, input logic dwa);
        in_valid   = 1'b1;
        data       = d;
        dwa_enable = dwa;
        out_ready  = 1'b1;
        #1;
        check("send_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    // Expected values that depend on whether DWA is built in.
`ifdef ADC_DECODER_DWA_EN
    localparam logic [31:0] EXP_C0_ROT  = 32'hBFFFFFFF;
    localparam logic [31:0] EXP_C25_ROT = 32'hC0018003;
    localparam logic [31:0] EXP_C3_ROT  = 32'h7FFE7FFE;
    localparam logic [31:0] EXP_C4_ROT  = 32'h9FFFFFF1;
    localparam logic [4:0]  EXP_P1 = 5'd3, EXP_P2 = 5'd4, EXP_P3 = 5'd30, EXP_P4 = 5'd2, EXP_P5 = 5'd7;
`else
    localparam logic [31:0] EXP_C0_ROT  = 32'hFFFFFFFE;
    localparam logic [31:0] EXP_C25_ROT = 32'h0007E000;
    localparam logic [31:0] EXP_C3_ROT  = 32'h3FFFFFFC;
    localparam logic [31:0] EXP_C4_ROT  = 32'h3FFFFFF8;
    localparam logic [4:0]  EXP_P1 = 5'd0, EXP_P2 = 5'd0, EXP_P3 = 5'd0, EXP_P4 = 5'd0, EXP_P5 = 5'd0;
`endif

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        data       = '0;
        dwa_enable = 1'b0;
        out_ready  = 1'b0;

        // 1. Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_c0_p_during", 64'(c0_p), 64'd1);
        check("rst_c0_n_during", 64'(c0_n), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_row_n", 64'(row_n), 64'hFFFF);
        check("rst_rowon_n", 64'(rowon_n), 64'hFFFF);
        check("rst_col_n", 64'(col_n), 64'hFFFFFFFF);
        check("rst_bincap_n", 64'(bincap_n), 64'h7);
        check("rst_rot_ptr", 64'(rot_ptr), 64'd0);
        check("rst_c0_p", 64'(c0_p), 64'd1);
        check("rst_c0_n", 64'(c0_n), 64'd0);

        // 2. Code-0 and full-scale words, no rotation.
        send(12'h000, 1'b0);
        check("z_out_valid", 64'(out_valid), 64'd1);
        check("z_row_n", 64'(row_n), 64'hFFFE);
        check("z_rowon_n", 64'(rowon_n), 64'hFFFF);
        check("z_col_n", 64'(col_n), 64'hFFFFFFFE);
        check("z_bincap_n", 64'(bincap_n), 64'h7);
        send(12'hFFF, 1'b0);
        check("f_row_n", 64'(row_n), 64'h0000);
        // r=15 turns rows 0..14 fully on, so only bit 15 stays high.
        check("f_rowon_n", 64'(rowon_n), 64'h8000);
        check("f_col_n", 64'(col_n), 64'h00000000);
        check("f_bincap_n", 64'(bincap_n), 64'h0);
        check("f_rot_ptr", 64'(rot_ptr), 64'd0);

        // 3. Interleave order, no rotation.
        send(12'h008, 1'b0);
        check("il_c1_col_n", 64'(col_n), 64'h7FFFFFFE);
        send(12'h010, 1'b0);
        check("il_c2_col_n", 64'(col_n), 64'h7FFFFFFC);

        // 4. DWA rotation, pointer starting from 0.
        send(12'h010, 1'b1);
        check("dwa_c2_col_n", 64'(col_n), 64'h7FFFFFFC);
        check("dwa_c2_ptr", 64'(rot_ptr), 64'(EXP_P1));
        send(12'h000, 1'b1);
        check("dwa_c0_col_n", 64'(col_n), 64'(EXP_C0_ROT));
        check("dwa_c0_ptr", 64'(rot_ptr), 64'(EXP_P2));
        send(12'h0C8, 1'b1);
        check("dwa_c25_col_n", 64'(col_n), 64'(EXP_C25_ROT));
        check("dwa_c25_ptr", 64'(rot_ptr), 64'(EXP_P3));
        send(12'h018, 1'b1);
        check("dwa_c3_col_n", 64'(col_n), 64'(EXP_C3_ROT));
        check("dwa_c3_ptr_wrap", 64'(rot_ptr), 64'(EXP_P4));

        // Drain with no new word: valid drops, decoded outputs hold.
        @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_col_hold", 64'(col_n), 64'(EXP_C3_ROT));

        // 5. Backpressure. W1 = {r=5,c=4,b=6} is accepted and held, and W2 is
        // offered meanwhile.
        in_valid   = 1'b1;
        data       = 12'h526;
        dwa_enable = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data       = 12'h201;       // W2 = {r=2,c=0,b=1}
        dwa_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_row_n", 64'(row_n), 64'hFFC0);
            check("bp_rowon_n", 64'(rowon_n), 64'hFFE0);
            check("bp_col_n", 64'(col_n), 64'(EXP_C4_ROT));
            check("bp_bincap_n", 64'(bincap_n), 64'h1);
            check("bp_rot_ptr", 64'(rot_ptr), 64'(EXP_P5));
            @(negedge clk);
        end
        // Release: W2 is accepted in the same cycle that W1 drains.
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("swap_out_valid", 64'(out_valid), 64'd1);
        check("swap_row_n", 64'(row_n), 64'hFFF8);
        check("swap_rowon_n", 64'(rowon_n), 64'hFFFC);
        check("swap_col_n", 64'(col_n), 64'hFFFFFFFE);
        check("swap_bincap_n", 64'(bincap_n), 64'h6);
        check("swap_rot_ptr", 64'(rot_ptr), 64'(EXP_P5));

        // 6. Reset while a word is held under backpressure.
        @(negedge clk);
        #1;
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_rot_ptr", 64'(rot_ptr), 64'd0);
        check("mid_rst_row_n", 64'(row_n), 64'hFFFF);
        check("mid_rst_rowon_n", 64'(rowon_n), 64'hFFFF);
        check("mid_rst_col_n", 64'(col_n), 64'hFFFFFFFF);
        check("mid_rst_bincap_n", 64'(bincap_n), 64'h7);
        check("mid_rst_c0_p", 64'(c0_p), 64'd1);
        check("mid_rst_c0_n", 64'(c0_n), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // After reset, rotation starts from pointer 0 again.
        send(12'h010, 1'b1);
        check("post_rst_col_n", 64'(col_n), 64'h7FFFFFFC);
        check("post_rst_ptr", 64'(rot_ptr), 64'(EXP_P1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
